// File: rtl/winograd_pe_stream.sv
// winograd_pe_stream: channel-serial Winograd F(2x2,3x3) processing element.
// Each accepted beat carries one channel's 4x4 input tile. The kernel for that
// channel comes from an internal store of pre-transformed kernels. Per-channel
// results are accumulated over CHANNELS beats, and one 2x2 output tile is then
// emitted on a valid/ready port.
//
// Ports:
//   clk, reset             clock; asynchronous active-low reset
//   k_valid, k_ch, Kernel  kernel write (always accepted; k_ch >= CHANNELS ignored)
//   in_valid, in_ready     input beat handshake
//   inpData                4x4 tile, element (r,c) at [(15-4r-c)*IW +: IW]
//   out_valid, out_ready   output tile handshake
//   outData                {y00, y01, y10, y11}, each OUT_W signed
//   ch_idx                 channel index the next accepted beat will use
module winograd_pe_stream #(
  parameter int unsigned CHANNELS          = 3,
  parameter int unsigned INPUT_DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_DATA_WIDTH = 8,
  parameter int unsigned RELU              = 0,
  localparam int unsigned CLOG_CH = $clog2(CHANNELS),
  localparam int unsigned ADDR_W  = (CLOG_CH < 1) ? 1 : CLOG_CH,
  localparam int unsigned OUT_W   = INPUT_DATA_WIDTH + KERNEL_DATA_WIDTH + 4 + CLOG_CH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            k_valid,
  input  logic [ADDR_W-1:0]               k_ch,
  input  logic [9*KERNEL_DATA_WIDTH-1:0]  Kernel,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [16*INPUT_DATA_WIDTH-1:0]  inpData,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [4*OUT_W-1:0]              outData,
  output logic [ADDR_W-1:0]               ch_idx
);

  localparam int unsigned IW      = INPUT_DATA_WIDTH;
  localparam int unsigned KW      = KERNEL_DATA_WIDTH;
  localparam int unsigned VW      = IW + 2;
  localparam int unsigned UW      = KW + 4;
  localparam int unsigned MW      = IW + KW + 6;
  localparam int unsigned YW      = IW + KW + 10;
  localparam int unsigned AW      = YW + CLOG_CH;
  localparam int unsigned KDEPTH  = 1 << ADDR_W;
  localparam int unsigned ADDR_W1 = ADDR_W + 1;

  // One output of B^T applied to a 4-vector.
  function automatic logic signed [VW-1:0] bt_row(input logic signed [VW-1:0] a, b, c, d,
                                                  input int unsigned k);
    bt_row = '0;
    case (k)
      0:       bt_row = a - c;
      1:       bt_row = b + c;
      2:       bt_row = c - b;
      default: bt_row = b - d;
    endcase
  endfunction

  // One output of G' = 2G applied to a 3-vector.
  function automatic logic signed [UW-1:0] g_row(input logic signed [UW-1:0] a, b, c,
                                                 input int unsigned k);
    g_row = '0;
    case (k)
      0:       g_row = a + a;
      1:       g_row = a + b + c;
      2:       g_row = a - b + c;
      default: g_row = c + c;
    endcase
  endfunction

  // One output of A^T applied to a 4-vector.
  function automatic logic signed [YW-1:0] a_row(input logic signed [YW-1:0] a, b, c, d,
                                                 input int unsigned k);
    a_row = '0;
    case (k)
      0:       a_row = a + b + c;
      default: a_row = b - c - d;
    endcase
  endfunction

  // Pipeline and store registers
  logic signed [UW-1:0] kstore_q [KDEPTH][16];
  logic signed [VW-1:0] v_q [16];
  logic signed [UW-1:0] u_q [16];
  logic signed [MW-1:0] m_q [16];
  logic signed [AW-1:0] acc_q [4];
  logic                 s1_valid_q, s1_first_q, s1_last_q;
  logic                 s2_valid_q, s2_first_q, s2_last_q;
  logic                 s3_valid_q, s3_last_q;
  logic                 out_valid_q, out_valid_d;
  logic [4*OUT_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]    ch_idx_q, ch_idx_d;

  // Combinational datapath values
  logic signed [UW-1:0] gk [3][3];
  logic signed [UW-1:0] gg [4][3];
  logic signed [UW-1:0] u_d [16];
  logic signed [VW-1:0] dt [4][4];
  logic signed [VW-1:0] bd [4][4];
  logic signed [VW-1:0] v_d [16];
  logic signed [MW-1:0] m_d [16];
  logic signed [YW-1:0] mt [4][4];
  logic signed [YW-1:0] am [2][4];
  logic signed [YW-1:0] y_d [4];
  logic signed [AW-1:0] acc_d [4];

  logic stall, accept, load, k_wr;

  // The final tile cannot leave S3 while the previous result is still unread.
  assign stall     = out_valid_q && !out_ready && s3_valid_q && s3_last_q;
  assign in_ready  = reset && !stall;
  assign accept    = in_valid && in_ready;
  assign load      = s3_valid_q && s3_last_q && !stall;
  assign k_wr      = k_valid && ({1'b0, k_ch} < ADDR_W1'(CHANNELS));

  assign out_valid = out_valid_q;
  assign outData   = out_data_q;
  assign ch_idx    = ch_idx_q;

  // Kernel transform U' = G' g G'^T, computed on the write path
  always_comb begin : kernel_xform
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned c = 0; c < 3; c++)
        gk[r][c] = UW'($signed(Kernel[(8 - 3*r - c)*KW +: KW]));
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned c = 0; c < 3; c++)
        gg[i][c] = g_row(gk[0][c], gk[1][c], gk[2][c], i);
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned j = 0; j < 4; j++)
        u_d[4*i + j] = g_row(gg[i][0], gg[i][1], gg[i][2], j);
  end

  // S1 input: V = B^T d B
  always_comb begin : input_xform
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        dt[r][c] = VW'($signed(inpData[(15 - 4*r - c)*IW +: IW]));
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned c = 0; c < 4; c++)
        bd[i][c] = bt_row(dt[0][c], dt[1][c], dt[2][c], dt[3][c], i);
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned j = 0; j < 4; j++)
        v_d[4*i + j] = bt_row(bd[i][0], bd[i][1], bd[i][2], bd[i][3], j);
  end

  // S2 input: elementwise product
  always_comb begin : hadamard
    for (int unsigned e = 0; e < 16; e++)
      m_d[e] = MW'(v_q[e]) * MW'(u_q[e]);
  end

  // S3 input: Y' = A^T M A, then restart or extend the accumulation
  always_comb begin : output_xform
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        mt[r][c] = YW'(m_q[4*r + c]);
    for (int unsigned i = 0; i < 2; i++)
      for (int unsigned c = 0; c < 4; c++)
        am[i][c] = a_row(mt[0][c], mt[1][c], mt[2][c], mt[3][c], i);
    for (int unsigned i = 0; i < 2; i++)
      for (int unsigned j = 0; j < 2; j++)
        y_d[2*i + j] = a_row(am[i][0], am[i][1], am[i][2], am[i][3], j);
    for (int unsigned k = 0; k < 4; k++)
      acc_d[k] = s2_first_q ? AW'(y_d[k]) : acc_q[k] + AW'(y_d[k]);
  end

  // Final scaling (G' = 2G gives a factor of 4), truncation and optional ReLU
  always_comb begin : finalize
    logic signed [OUT_W-1:0] y_fin;
    out_data_d = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      y_fin = OUT_W'(acc_q[k] >>> 2);
      if (RELU != 0 && y_fin[OUT_W-1]) y_fin = '0;
      out_data_d[(3 - k)*OUT_W +: OUT_W] = y_fin;
    end
  end

  // Channel sequencing and output handshake next state
  always_comb begin : ctrl_next
    ch_idx_d    = ch_idx_q;
    out_valid_d = out_valid_q;
    if (accept)
      ch_idx_d = (ch_idx_q == ADDR_W'(CHANNELS - 1)) ? '0 : ch_idx_q + ADDR_W'(1);
    if (load)
      out_valid_d = 1'b1;
    else if (out_ready)
      out_valid_d = 1'b0;
  end

  // Kernel store; S1 reads the old entry on a same-cycle write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned a = 0; a < KDEPTH; a++)
        for (int unsigned e = 0; e < 16; e++)
          kstore_q[a][e] <= '0;
    end else if (k_wr) begin
      for (int unsigned e = 0; e < 16; e++)
        kstore_q[k_ch][e] <= u_d[e];
    end
  end

  // Three-stage datapath, frozen as a whole on stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      for (int unsigned e = 0; e < 16; e++) begin
        v_q[e] <= '0;
        u_q[e] <= '0;
        m_q[e] <= '0;
      end
      for (int unsigned k = 0; k < 4; k++)
        acc_q[k] <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_first_q <= (ch_idx_q == '0);
        s1_last_q  <= (ch_idx_q == ADDR_W'(CHANNELS - 1));
        for (int unsigned e = 0; e < 16; e++) begin
          v_q[e] <= v_d[e];
          u_q[e] <= kstore_q[ch_idx_q][e];
        end
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        for (int unsigned e = 0; e < 16; e++)
          m_q[e] <= m_d[e];
      end
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_last_q <= s2_last_q;
        for (int unsigned k = 0; k < 4; k++)
          acc_q[k] <= acc_d[k];
      end
    end
  end

  // Output register and channel counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ch_idx_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ch_idx_q    <= ch_idx_d;
      if (load) out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_winograd_pe_stream.sv
// Testbench for winograd_pe_stream. Reference: direct 3x3 correlation summed
// over channels, tracked per accepted beat with the kernels in force at that
// moment.
module tb_winograd_pe_stream;

  localparam int CH  = 3;
  localparam int OW3 = 8 + 8 + 4 + 2;
  localparam int OW1 = 8 + 8 + 4 + 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Shared stimulus for the two CHANNELS=3 instances (RELU=0 and RELU=1)
  logic          k_valid, in_valid, out_ready;
  logic [1:0]    k_ch;
  logic [71:0]   kern;
  logic [127:0]  tile;
  logic          in_ready, in_ready_r, out_valid, out_valid_r;
  logic [4*OW3-1:0] out_data, out_data_r;
  logic [1:0]    ch_idx, ch_idx_r;

  // CHANNELS=1 instance
  logic          k_valid1, in_valid1, out_ready1, in_ready1, out_valid1;
  logic [0:0]    k_ch1, ch_idx1;
  logic [71:0]   kern1;
  logic [127:0]  tile1;
  logic [4*OW1-1:0] out_data1;

  winograd_pe_stream #(.CHANNELS(3), .INPUT_DATA_WIDTH(8), .KERNEL_DATA_WIDTH(8), .RELU(0)) dut (
    .clk(clk), .reset(rst_n), .k_valid(k_valid), .k_ch(k_ch), .Kernel(kern),
    .in_valid(in_valid), .in_ready(in_ready), .inpData(tile),
    .out_valid(out_valid), .out_ready(out_ready), .outData(out_data), .ch_idx(ch_idx));

  winograd_pe_stream #(.CHANNELS(3), .INPUT_DATA_WIDTH(8), .KERNEL_DATA_WIDTH(8), .RELU(1)) dut_relu (
    .clk(clk), .reset(rst_n), .k_valid(k_valid), .k_ch(k_ch), .Kernel(kern),
    .in_valid(in_valid), .in_ready(in_ready_r), .inpData(tile),
    .out_valid(out_valid_r), .out_ready(out_ready), .outData(out_data_r), .ch_idx(ch_idx_r));

  winograd_pe_stream #(.CHANNELS(1), .INPUT_DATA_WIDTH(8), .KERNEL_DATA_WIDTH(8), .RELU(0)) dut1 (
    .clk(clk), .reset(rst_n), .k_valid(k_valid1), .k_ch(k_ch1), .Kernel(kern1),
    .in_valid(in_valid1), .in_ready(in_ready1), .inpData(tile1),
    .out_valid(out_valid1), .out_ready(out_ready1), .outData(out_data1), .ch_idx(ch_idx1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [71:0] kconst(input int v);
    logic [71:0] k;
    for (int i = 0; i < 9; i++) k[i*8 +: 8] = 8'(v);
    return k;
  endfunction

  function automatic logic [71:0] kat(input int r, input int c, input int v);
    logic [71:0] k;
    k = '0;
    k[(8 - 3*r - c)*8 +: 8] = 8'(v);
    return k;
  endfunction

  function automatic logic [127:0] tconst(input int v);
    logic [127:0] t;
    for (int i = 0; i < 16; i++) t[i*8 +: 8] = 8'(v);
    return t;
  endfunction

  function automatic logic [127:0] tramp();
    logic [127:0] t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[(15 - 4*r - c)*8 +: 8] = 8'(4*r + c + 1);
    return t;
  endfunction

  // y(i,j) = sum over r,c of d(i+r, j+c) * g(r,c)
  function automatic int conv(input logic [127:0] t, input logic [71:0] k, input int i, input int j);
    logic signed [7:0] a, b;
    int s;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a = t[(15 - 4*(i + r) - (j + c))*8 +: 8];
        b = k[(8 - 3*r - c)*8 +: 8];
        s += int'(a) * int'(b);
      end
    return s;
  endfunction

  function automatic int fld3(input logic [4*OW3-1:0] d, input int k);
    logic signed [OW3-1:0] f;
    f = d[(3 - k)*OW3 +: OW3];
    return int'(f);
  endfunction

  function automatic int fld1(input logic [4*OW1-1:0] d, input int k);
    logic signed [OW1-1:0] f;
    f = d[(3 - k)*OW1 +: OW1];
    return int'(f);
  endfunction

  // Reference model state
  logic [71:0]      kmod [CH];
  int               part [4];
  int               mch;
  int               exp_q [$];
  int               tile_log [$];
  int               last_y [4];
  int               last_yr [4];
  logic             prev_hold;
  logic [4*OW3-1:0] prev_data;

  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      mch = 0;
      exp_q.delete();
      prev_hold = 1'b0;
      for (int k = 0; k < 4; k++) part[k] = 0;
      for (int c = 0; c < CH; c++) kmod[c] = '0;
    end else begin
      if (prev_hold) chk("hold_stable", int'(out_data == prev_data), 1);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (in_valid && in_ready) begin
        chk("ch_idx", int'(ch_idx), mch);
        chk("ch_idx_relu", int'(ch_idx_r), mch);
        for (int k = 0; k < 4; k++)
          part[k] = ((mch == 0) ? 0 : part[k]) + conv(tile, kmod[mch], k / 2, k % 2);
        if (mch == CH - 1)
          for (int k = 0; k < 4; k++) exp_q.push_back(part[k]);
        mch = (mch + 1) % CH;
      end
      if (k_valid && int'(k_ch) < CH) kmod[k_ch] = kern;
      if (out_valid && out_ready) begin
        chk("relu_valid", int'(out_valid_r), 1);
        if (exp_q.size() < 4) chk("unexpected_tile", 1, 0);
        else begin
          for (int k = 0; k < 4; k++) begin
            int e;
            e = exp_q.pop_front();
            last_y[k]  = fld3(out_data, k);
            last_yr[k] = fld3(out_data_r, k);
            chk("y", last_y[k], e);
            chk("y_relu", last_yr[k], (e < 0) ? 0 : e);
          end
          tile_log.push_back(last_y[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_k(input int ch, input logic [71:0] k);
    k_valid = 1'b1;
    k_ch    = 2'(ch);
    kern    = k;
    tick();
    k_valid = 1'b0;
  endtask

  task automatic load_all(input int v);
    for (int c = 0; c < CH; c++) wr_k(c, kconst(v));
  endtask

  task automatic beat(input logic [127:0] t);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    tile     = t;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  typedef struct packed {
    logic [71:0]  k;
    logic [127:0] t;
    logic signed [31:0] y0, y1, y2, y3;
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t tbl [7];
    int   n0, lat, yexp;
    logic [4*OW3-1:0] held;

    tbl[0] = '{kat(1, 1, 1),     tramp(),      32'sd6,       32'sd7,       32'sd10,      32'sd11};
    tbl[1] = '{kconst(1),        tconst(1),    32'sd9,       32'sd9,       32'sd9,       32'sd9};
    tbl[2] = '{kconst(1),        tramp(),      32'sd54,      32'sd63,      32'sd90,      32'sd99};
    tbl[3] = '{kat(0, 0, 1),     tramp(),      32'sd1,       32'sd2,       32'sd5,       32'sd6};
    tbl[4] = '{kconst(-128),     tconst(-128), 32'sd147456,  32'sd147456,  32'sd147456,  32'sd147456};
    tbl[5] = '{kconst(-128),     tconst(127),  -32'sd146304, -32'sd146304, -32'sd146304, -32'sd146304};
    tbl[6] = '{kat(2, 2, -1),    tramp(),      -32'sd11,     -32'sd12,     -32'sd15,     -32'sd16};

    rst_n = 1'b0;
    k_valid = 0; k_ch = '0; kern = '0; in_valid = 0; tile = '0; out_ready = 1;
    k_valid1 = 0; k_ch1 = '0; kern1 = '0; in_valid1 = 0; tile1 = '0; out_ready1 = 1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_in_ready_relu", int'(in_ready_r), 0);
    chk("rst_in_ready1", int'(in_ready1), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_zero", int'(out_data != '0), 0);
    chk("rst_ch_idx", int'(ch_idx), 0);
    chk("rst_ch_idx1", int'(ch_idx1), 0);
    chk("post_rst_in_ready", int'(in_ready), 1);
    tick();

    // Multi-channel accumulation, back-to-back beats
    load_all(1);
    out_ready = 1'b1;
    n0 = tile_log.size();
    for (int i = 0; i < 6; i++) begin
      chk("seq_ch_idx", int'(ch_idx), i % 3);
      beat(tconst(1));
    end
    drain(6);
    chk("acc_tiles", tile_log.size() - n0, 2);
    for (int k = 0; k < 4; k++) chk("acc_y27", last_y[k], 27);

    // Sign and ReLU
    load_all(-1);
    for (int i = 0; i < 3; i++) beat(tconst(1));
    drain(6);
    for (int k = 0; k < 4; k++) begin
      chk("neg_y", last_y[k], -27);
      chk("relu_y", last_yr[k], 0);
    end

    // Backpressure with continuous input
    load_all(1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tile      = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int n = 0; n < 50 && !out_valid; n++) begin
      tick();
      tile = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    chk("bp_first_valid", int'(out_valid), 1);
    repeat (5) begin
      tick();
      tile = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    held = out_data;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_hold", int'(out_data == held), 1);
      tick();
      tile = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    out_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      tile = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (mch == 0) break;
    end
    drain(10);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Kernel write colliding with a channel-0 beat
    chk("coll_ch0", int'(ch_idx), 0);
    n0 = tile_log.size();
    k_valid = 1'b1; k_ch = 2'd0; kern = kconst(2);
    in_valid = 1'b1; tile = tconst(1);
    @(negedge clk);
    chk("coll_ready", int'(in_ready), 1);
    tick();
    k_valid = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) beat(tconst(1));
    drain(8);
    chk("coll_tiles", tile_log.size() - n0, 2);
    chk("coll_old_kernel", tile_log[n0], 27);
    chk("coll_new_kernel", tile_log[n0 + 1], 36);

    // Reset in the middle of a tile
    beat(tconst(1));
    beat(tconst(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_ch_idx", int'(ch_idx), 0);
    tick();
    rst_n = 1'b1;
    n0 = tile_log.size();
    load_all(1);
    chk("post_rst_out_valid", int'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_quiet", int'(out_valid), 0);
      beat(tconst(1));
    end
    drain(8);
    chk("post_rst_tiles", tile_log.size() - n0, 1);
    for (int k = 0; k < 4; k++) chk("post_rst_y27", last_y[k], 27);

    // Randomized traffic: bubbles, backpressure, kernel rewrites (incl. ignored k_ch=3)
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      tile      = {$urandom(), $urandom(), $urandom(), $urandom()};
      k_valid   = ($urandom_range(0, 5) == 0);
      k_ch      = 2'($urandom_range(0, 3));
      kern      = 72'({$urandom(), $urandom(), $urandom()});
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    k_valid = 1'b0;
    drain(12);
    chk("rand_queue_empty", exp_q.size(), 0);

    // Single-channel vector table with latency check
    for (int v = 0; v < 7; v++) begin
      k_valid1 = 1'b1; kern1 = tbl[v].k;
      tick();
      k_valid1 = 1'b0;
      in_valid1 = 1'b1; tile1 = tbl[v].t;
      @(negedge clk);
      chk("tbl_in_ready", int'(in_ready1), 1);
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
        tick();
        if (out_valid1) begin
          lat = n;
          break;
        end
      end
      chk("tbl_latency", lat, 3);
      for (int k = 0; k < 4; k++) begin
        case (k)
          0:       yexp = tbl[v].y0;
          1:       yexp = tbl[v].y1;
          2:       yexp = tbl[v].y2;
          default: yexp = tbl[v].y3;
        endcase
        chk("tbl_y", fld1(out_data1, k), yexp);
      end
      tick();
      chk("tbl_valid_clear", int'(out_valid1), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
